// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants and state encoding for the UART transmit arbiter.
// The baud timing constants size the default stall timeout of the top level.
package uart_tx_arbiter_pkg;

  localparam int CLK_FREQ_MHZ  = 50;
  localparam int BAUD          = 115200;
  localparam int CYC_PER_BIT   = 434;
  localparam int CYC_PER_FRAME = 4340;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the UART transmit arbiter.
// master = requesters plus uart_tx, slave = the arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      tx_valid;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_ready;
  logic [NUM_REQ-1:0]        grant;
  logic                      busy;
  logic                      timeout_pulse;

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data, grant, busy, timeout_pulse
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data, grant, busy, timeout_pulse
  );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first requester above last_winner, wrapping.
// The request vector is doubled and shifted so the search is a plain priority scan.
module uart_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_winner,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  int                   shift;
  int                   pos;

  always_comb begin
    req_dbl    = {req, req};
    shift      = int'(last_winner) + 1;
    req_rot    = NUM_REQ'(req_dbl >> shift);
    winner     = '0;
    winner_idx = '0;
    pos        = 0;
    // Descending scan: the lowest rotated offset is written last and wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        pos = shift + i;
        if (pos >= NUM_REQ) pos = pos - NUM_REQ;
        winner     = NUM_REQ'(1) << pos;
        winner_idx = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet lock sharing one uart_tx among NUM_REQ byte streams.
// Define UART_ARB_TIMEOUT_EN to force-release an owner that stalls for TIMEOUT_CYC cycles.
//
//  state   | meaning
//  --------+----------------------------------------------------------
//  ST_IDLE | no owner; registers a round-robin grant when any req_valid
//  ST_XFER | owner's stream passes straight through until a last byte
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16 * CYC_PER_FRAME
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("NUM_REQ must be 2..8");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be positive");
  end

  arb_state_t         state;
  logic [NUM_REQ-1:0] grant_q;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   last_winner;
  logic               busy_q;
  logic [NUM_REQ-1:0] pick;
  logic [IDX_W-1:0]   pick_idx;
  logic               tx_valid_c;
  logic [DATA_W-1:0]  tx_data_c;
  logic [NUM_REQ-1:0] req_ready_c;
  logic               xfer_fire;

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req         (bus.req_valid),
    .last_winner (last_winner),
    .winner      (pick),
    .winner_idx  (pick_idx)
  );

  // The arbiter holds no data: the owner's byte is muxed through untouched.
  always_comb begin
    tx_valid_c  = 1'b0;
    tx_data_c   = '0;
    req_ready_c = '0;
    if (state == ST_XFER) begin
      tx_valid_c         = bus.req_valid[owner];
      req_ready_c[owner] = bus.tx_ready;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (owner == IDX_W'(i)) tx_data_c = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign xfer_fire = tx_valid_c & bus.tx_ready;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMR_W-1:0] stall_left;
  logic             timeout_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      grant_q     <= '0;
      owner       <= '0;
      last_winner <= IDX_W'(NUM_REQ - 1);
      busy_q      <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      stall_left  <= TMR_W'(TIMEOUT_CYC);
      timeout_q   <= 1'b0;
`endif
    end else begin
`ifdef UART_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (|bus.req_valid) begin
            state   <= ST_XFER;
            grant_q <= pick;
            owner   <= pick_idx;
            busy_q  <= 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
            stall_left <= TMR_W'(TIMEOUT_CYC);
`endif
          end
        end
        ST_XFER: begin
          if (xfer_fire) begin
            if (bus.req_last[owner]) begin
              state       <= ST_IDLE;
              grant_q     <= '0;
              busy_q      <= 1'b0;
              last_winner <= owner;
            end
`ifdef UART_ARB_TIMEOUT_EN
            stall_left <= TMR_W'(TIMEOUT_CYC);
          end else if (!tx_valid_c) begin
            // Down-counter reaching its last step is the TIMEOUT_CYC-th idle cycle.
            if (stall_left == TMR_W'(1)) begin
              state       <= ST_IDLE;
              grant_q     <= '0;
              busy_q      <= 1'b0;
              last_winner <= owner;
              timeout_q   <= 1'b1;
            end else begin
              stall_left <= stall_left - 1'b1;
            end
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;
  assign bus.tx_valid  = tx_valid_c;
  assign bus.tx_data   = tx_data_c;
  assign bus.req_ready = req_ready_c;
`ifdef UART_ARB_TIMEOUT_EN
  assign bus.timeout_pulse = timeout_q;
`else
  assign bus.timeout_pulse = 1'b0;
`endif

endmodule
